// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and issue-FSM states for the 16-bit ALU interface.
package alu_pkg;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;
  localparam logic [2:0] OP_SHIFT = 3'b110;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op != 3'b000) && (op != 3'b111);
  endfunction
endpackage

// File: rtl/alu_shift_chunker.sv
// Splits a 0..2^SHAMT_W-1 shift into ALU passes of at most 3 places each.
module alu_shift_chunker #(
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [SHAMT_W-1:0] amt,
  input  logic               step,
  output logic [1:0]         sel,
  output logic               last_pass
);
  logic [SHAMT_W-1:0] rem;

  // A zero amount still yields one pass with sel 0.
  assign last_pass = (rem <= SHAMT_W'(3));
  assign sel       = last_pass ? rem[1:0] : 2'd3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rem <= '0;
    else if (load) rem <= amt;
    else if (step) rem <= rem - SHAMT_W'(sel);
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Request/response front end for the 16-bit ALU: sequences ops and multi-pass shifts, keeps status flags.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int W       = 16,
  parameter int SHAMT_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic         req_setflags,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_ctl,
  input  logic [W-1:0] alu_out,
  input  logic [3:0]   alu_flags,
  output logic [3:0]   status_flags
);
  state_e       state;
  logic [2:0]   op_q;
  logic [W-1:0] a_q, b_q;
  logic         setf_q;
  logic         accept, addsub;
  logic [1:0]   sel;
  logic         last_pass;
  logic [3:0]   res_flags;

  assign req_ready = (state == IDLE) || (state == RESP && rsp_ready);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign addsub    = (op_q == OP_ADD) || (op_q == OP_SUB);

  // Logic ops and shifts leave the ALU's v/c stale, so the architectural v/c carry through.
  assign res_flags = {alu_flags[FLAG_Z], alu_flags[FLAG_N],
                      addsub ? alu_flags[FLAG_V] : status_flags[FLAG_V],
                      addsub ? alu_flags[FLAG_C] : status_flags[FLAG_C]};

  alu_shift_chunker #(.SHAMT_W(SHAMT_W)) u_chunker (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept && req_op == OP_SHIFT),
    .amt       (req_b[SHAMT_W-1:0]),
    .step      (state == SHIFT),
    .sel       (sel),
    .last_pass (last_pass)
  );

  // AND is the idle control code so the ALU never sees its hold-on-default encoding.
  always_comb begin
    alu_ctl = OP_AND;
    alu_a   = '0;
    alu_b   = '0;
    case (state)
      EXEC: begin
        alu_ctl = op_q;
        alu_a   = a_q;
        alu_b   = b_q;
      end
      SHIFT: begin
        alu_ctl = OP_SHIFT;
        alu_a   = a_q;
        alu_b   = {{(W-2){1'b0}}, sel};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= OP_AND;
      a_q          <= '0;
      b_q          <= '0;
      setf_q       <= 1'b0;
      rsp_result   <= '0;
      rsp_flags    <= '0;
      rsp_err      <= 1'b0;
      status_flags <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (state == RESP && rsp_ready) state <= IDLE;
          if (accept) begin
            op_q   <= req_op;
            a_q    <= req_a;
            b_q    <= req_b;
            setf_q <= req_setflags;
            if (!op_legal(req_op)) begin
              state      <= RESP;
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_flags  <= status_flags;
            end else if (req_op == OP_SHIFT) begin
              state <= SHIFT;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC, SHIFT: begin
          // a_q doubles as the running value between shift passes.
          if (state == SHIFT) a_q <= alu_out;
          if (state == EXEC || last_pass) begin
            state      <= RESP;
            rsp_result <= alu_out;
            rsp_flags  <= res_flags;
            rsp_err    <= 1'b0;
            if (setf_q) status_flags <= res_flags;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl driving a behavioural 16-bit ALU with a 0..3 place left shifter.
module tb_alu_issue_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0, req_ready;
  logic [2:0]   req_op = 3'b000;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic         req_setflags = 1'b0;
  logic         rsp_valid, rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic         rsp_err;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [2:0]   alu_ctl;
  logic [3:0]   alu_flags, status_flags;

  int n_chk = 0;
  int n_fail = 0;

  alu_issue_ctrl #(.W(W), .SHAMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_setflags(req_setflags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
    .alu_out(alu_out), .alu_flags(alu_flags), .status_flags(status_flags)
  );

  always #5 clk = ~clk;

  // ALU model: logic ops and shifts report garbage v/c=11 that the controller must ignore.
  logic [W:0] sum;
  logic       vv, cc;
  always_comb begin
    sum     = '0;
    vv      = 1'b1;
    cc      = 1'b1;
    alu_out = '0;
    case (alu_ctl)
      3'b001: begin
        sum     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = sum[W-1:0];
        cc      = sum[W];
        vv      = (alu_a[W-1] == alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
      end
      3'b010: begin
        sum     = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
        alu_out = sum[W-1:0];
        cc      = sum[W];
        vv      = (alu_a[W-1] != alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
      end
      3'b011: alu_out = alu_a & alu_b;
      3'b100: alu_out = alu_a | alu_b;
      3'b101: alu_out = alu_a ^ alu_b;
      3'b110: alu_out = alu_a << alu_b[1:0];
      default: alu_out = 16'hDEAD;
    endcase
    alu_flags = {alu_out == '0, alu_out[W-1], vv, cc};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sf);
    int n = 0;
    req_op = op; req_a = a; req_b = b; req_setflags = sf; req_valid = 1'b1;
    while (!req_ready && n < 50) begin step(); n++; end
    chk("issue_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    req_a = 16'hFFFF; req_b = 16'hFFFF; req_op = 3'b111;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 50) begin step(); n++; end
    chk("rsp_timeout", rsp_valid, 1'b1);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    step(); step();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_result", rsp_result, 16'h0);
    chk("rst_flags", rsp_flags, 4'h0);
    chk("rst_err", rsp_err, 1'b0);
    chk("rst_status", status_flags, 4'h0);
    chk("rst_alu_ctl", alu_ctl, 3'b011);
    chk("rst_alu_ab", {alu_a, alu_b}, 32'h0);
    rst_n = 1'b1;
    step();

    // add overflow, 2-cycle latency
    issue(3'b001, 16'h7FFF, 16'h0001, 1'b1);
    chk("add_exec_ctl", alu_ctl, 3'b001);
    chk("add_exec_a", alu_a, 16'h7FFF);
    chk("add_exec_b", alu_b, 16'h0001);
    chk("add_busy_ready", req_ready, 1'b0);
    chk("add_rsp_early", rsp_valid, 1'b0);
    step();
    chk("add_rsp_valid", rsp_valid, 1'b1);
    chk("add_result", rsp_result, 16'h8000);
    chk("add_flags", rsp_flags, 4'b0110);
    chk("add_status", status_flags, 4'b0110);
    ack();
    chk("add_rsp_drop", rsp_valid, 1'b0);

    // chunked shift 7 = 3,3,1; v,c inherited from status 0110
    issue(3'b110, 16'h00FF, 16'h0007, 1'b1);
    chk("sh_p1_ctl", alu_ctl, 3'b110);
    chk("sh_p1_a", alu_a, 16'h00FF);
    chk("sh_p1_b", alu_b, 16'h0003);
    step();
    chk("sh_p2_ctl", alu_ctl, 3'b110);
    chk("sh_p2_b", alu_b, 16'h0003);
    step();
    chk("sh_p3_ctl", alu_ctl, 3'b110);
    chk("sh_p3_b", alu_b, 16'h0001);
    step();
    chk("sh_rsp_valid", rsp_valid, 1'b1);
    chk("sh_result", rsp_result, 16'h7F80);
    chk("sh_flags", rsp_flags, 4'b0010);
    chk("sh_status", status_flags, 4'b0010);
    chk("sh_idle_ctl", alu_ctl, 3'b011);
    ack();

    // subtract, no borrow
    issue(3'b010, 16'd400, 16'd70, 1'b1);
    wait_rsp();
    chk("sub_result", rsp_result, 16'h014A);
    chk("sub_flags", rsp_flags, 4'b0001);
    chk("sub_status", status_flags, 4'b0001);
    ack();

    // backpressure then zero-bubble accept
    issue(3'b011, 16'hF0F0, 16'h0FF0, 1'b0);
    wait_rsp();
    chk("and_result", rsp_result, 16'h00F0);
    chk("and_flags", rsp_flags, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_result", rsp_result, 16'h00F0);
      chk("bp_flags", rsp_flags, 4'b0001);
      chk("bp_req_ready", req_ready, 1'b0);
    end
    req_op = 3'b101; req_a = 16'h00FF; req_b = 16'h0F0F; req_setflags = 1'b0;
    req_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("bp_pass_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0; rsp_ready = 1'b0;
    chk("b2b_exec_ctl", alu_ctl, 3'b101);
    chk("b2b_rsp_drop", rsp_valid, 1'b0);
    step();
    chk("xor_valid", rsp_valid, 1'b1);
    chk("xor_result", rsp_result, 16'h0FF0);
    chk("xor_flags", rsp_flags, 4'b0001);
    ack();

    // illegal opcode
    issue(3'b111, 16'h1234, 16'h5678, 1'b1);
    chk("ill_ctl", alu_ctl, 3'b011);
    chk("ill_valid", rsp_valid, 1'b1);
    chk("ill_err", rsp_err, 1'b1);
    chk("ill_result", rsp_result, 16'h0);
    chk("ill_flags", rsp_flags, 4'b0001);
    chk("ill_status", status_flags, 4'b0001);
    ack();

    // reset during the 2nd pass of a 15-place shift
    issue(3'b110, 16'h0001, 16'h000F, 1'b1);
    step();
    chk("rs_p2_a", alu_a, 16'h0008);
    chk("rs_p2_b", alu_b, 16'h0003);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_valid", rsp_valid, 1'b0);
    chk("rs_status", status_flags, 4'h0);
    chk("rs_ready", req_ready, 1'b1);
    chk("rs_ctl", alu_ctl, 3'b011);
    step();
    rst_n = 1'b1;
    step();
    issue(3'b100, 16'h0F00, 16'h00F0, 1'b1);
    chk("post_rs_early", rsp_valid, 1'b0);
    step();
    chk("post_rs_valid", rsp_valid, 1'b1);
    chk("post_rs_result", rsp_result, 16'h0FF0);
    chk("post_rs_err", rsp_err, 1'b0);
    chk("post_rs_flags", rsp_flags, 4'b0000);
    ack();

    // full 15-place shift: 5 passes, 1 << 15
    issue(3'b110, 16'h0001, 16'h000F, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("sh15_busy", rsp_valid, 1'b0);
      step();
    end
    chk("sh15_b_last", rsp_valid, 1'b0);
    step();
    chk("sh15_valid", rsp_valid, 1'b1);
    chk("sh15_result", rsp_result, 16'h8000);
    chk("sh15_flags", rsp_flags, 4'b0100);
    ack();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
